// File: rtl/serial_deserializer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_deserializer_pkg : shared types for the serial-to-parallel receiver
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } deser_state_t;

endpackage : serial_deserializer_pkg
`default_nettype wire

// File: rtl/serial_deserializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_deserializer_if : serial input link and word output handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             serial_in;
    logic             bit_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             busy;
    logic             frame_abort;
    logic             overrun;

    modport master (
        output start, serial_in, bit_valid, out_ready,
        input  data_out, out_valid, busy, frame_abort, overrun
    );

    modport slave (
        input  start, serial_in, bit_valid, out_ready,
        output data_out, out_valid, busy, frame_abort, overrun
    );
endinterface : serial_deserializer_if
`default_nettype wire

// File: rtl/serial_deserializer_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_deserializer_reg : enable-loaded holding register, async clear
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_deserializer_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clock,
    input  wire logic             clear,
    input  wire logic             en_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : serial_deserializer_reg
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_deserializer : start-framed serial receiver, valid/ready word output
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic           clock,
    input  wire logic           clear,
    serial_deserializer_if.slave bus
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic             abort_q, abort_d;
    logic             overrun_q, overrun_d;
    logic             w_load;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_data;

    if (MSB_FIRST) begin : g_msb_first
        assign w_shifted = {sreg_q[WIDTH-2:0], bus.serial_in};
    end else begin : g_lsb_first
        assign w_shifted = {bus.serial_in, sreg_q[WIDTH-1:1]};
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            count_q   <= '0;
            sreg_q    <= '0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sreg_q    <= sreg_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sreg_d    = sreg_q;
        abort_d   = 1'b0;
        overrun_d = overrun_q;
        w_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    count_d = '0;
                    sreg_d  = '0;
                end
            end
            SHIFT: begin
                // A restart outranks a coincident data bit.
                if (bus.start) begin
                    count_d = '0;
                    sreg_d  = '0;
                    abort_d = 1'b1;
                end else if (bus.bit_valid) begin
                    sreg_d = w_shifted;
                    if (count_q == c_last) begin
                        w_load  = 1'b1;
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.bit_valid) begin
                    overrun_d = 1'b1;
                end
                if (bus.out_ready) begin
                    if (bus.start) begin
                        state_d = SHIFT;
                        count_d = '0;
                        sreg_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    serial_deserializer_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clock (clock),
        .clear (clear),
        .en_i  (w_load),
        .d_i   (w_shifted),
        .q_o   (w_data)
    );

    assign bus.data_out    = w_data;
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.busy        = (state_q == SHIFT);
    assign bus.frame_abort = abort_q;
    assign bus.overrun     = overrun_q;

endmodule : serial_deserializer
`default_nettype wire
